mac_dot_seq: RTL and testbench

Sequential dot-product engine for the MAC coprocessor. It accepts a stream of packed 4-lane operand beats, each holding four unsigned 8-bit activations and four signed 8-bit weights. Per beat it forms the 4-lane signed product sum and accumulates it onto a 32-bit bias-initialised accumulator. After a programmed number of beats it presents the 32-bit result on a valid/ready output port. It sits between the coprocessor operand/dispatch logic (upstream) and result writeback (downstream).

---
 rtl/mac_dot_seq.sv | 168 ++++++++++++++++
 tb/tb_mac_dot_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_seq.sv
// -----------------------------------------------------------------------------
// mac_dot_seq
//
// Sequential 4-lane dot-product engine for the MAC coprocessor. Each operand
// beat carries four unsigned 8-bit activations and four signed 8-bit weights.
// The per-beat signed product sum is added onto a 32-bit accumulator, which is
// initialised from the job bias. After the programmed number of beats, the
// result is presented on a valid/ready port.
//
// Optional feature (compile-time macro MAC_RELU_EN):
//   defined   : res_o = (acc < 0) ? 0 : acc   (acc and ovf_o are unaffected)
//   undefined : res_o = acc, raw signed
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_ni       in   asynchronous active-low reset
//   start_i      in   job start; captures len_i and bias_i
//   len_i        in   beat count of the job (0 is legal)
//   bias_i       in   signed initial accumulator value
//   in_valid_i   in   operand beat valid
//   in_ready_o   out  operand beat accepted (high only while accumulating)
//   act_i        in   activations, unsigned byte per lane, lane k = [8k+7:8k]
//   wgt_i        in   weights, signed byte per lane, same lane mapping
//   res_valid_o  out  result valid
//   res_ready_i  in   downstream accepts the result
//   res_o        out  signed result
//   ovf_o        out  sticky signed-overflow flag for the current/last job
//   busy_o       out  high whenever the engine is not idle
// -----------------------------------------------------------------------------
module mac_dot_seq #(
    parameter int LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [31:0]      bias_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      act_i,
    input  logic [31:0]      wgt_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [31:0]      res_o,
    output logic             ovf_o,
    output logic             busy_o
);

    // state | meaning
    // IDLE  | waiting for start_i
    // ACCUM | accepting operand beats, one per cycle
    // DONE  | result held on res_o until res_ready_i
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [31:0]      acc, acc_nx;
    logic [LEN_W-1:0] cnt, cnt_nx;
    logic [LEN_W-1:0] len, len_nx;
    logic             ovf, ovf_nx;
    logic [31:0]      res, res_nx;

    logic signed [17:0] dot_sum;
    logic [31:0]        dot_ext;
    logic [31:0]        acc_sum;
    logic               add_ovf;
    logic               take_start;

    function automatic logic [31:0] post_proc(input logic [31:0] v);
`ifdef MAC_RELU_EN
        return v[31] ? 32'd0 : v;
`else
        return v;
`endif
    endfunction

    // Activation is zero-extended to 9 bits so the product is a plain signed
    // multiply; every lane product fits comfortably in 17 bits.
    always_comb begin
        logic signed [16:0] prod;
        prod    = '0;
        dot_sum = '0;
        for (int k = 0; k < 4; k++) begin
            prod    = 17'($signed({1'b0, act_i[8*k +: 8]})) * 17'($signed(wgt_i[8*k +: 8]));
            dot_sum = dot_sum + 18'(prod);
        end
    end

    assign dot_ext = 32'(dot_sum);
    assign acc_sum = acc + dot_ext;
    assign add_ovf = (acc[31] == dot_ext[31]) && (acc_sum[31] != acc[31]);

    // A start is honoured from IDLE, or in DONE on the very cycle the result
    // is consumed so back-to-back jobs need no idle bubble.
    assign take_start = start_i && ((state == IDLE) || ((state == DONE) && res_ready_i));

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        len_nx   = len;
        ovf_nx   = ovf;
        res_nx   = res;

        case (state)
            ACCUM: begin
                if (in_valid_i) begin
                    acc_nx = acc_sum;
                    cnt_nx = cnt + LEN_W'(1);
                    if (add_ovf) begin
                        ovf_nx = 1'b1;
                    end
                    if (cnt == len - LEN_W'(1)) begin
                        state_nx = DONE;
                        res_nx   = post_proc(acc_sum);
                    end
                end
            end
            DONE: begin
                if (res_ready_i) begin
                    state_nx = IDLE;
                end
            end
            default: ;
        endcase

        if (take_start) begin
            acc_nx = bias_i;
            cnt_nx = '0;
            ovf_nx = 1'b0;
            len_nx = len_i;
            if (len_i == '0) begin
                state_nx = DONE;
                res_nx   = post_proc(bias_i);
            end else begin
                state_nx = ACCUM;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            len   <= '0;
            ovf   <= 1'b0;
            res   <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            len   <= len_nx;
            ovf   <= ovf_nx;
            res   <= res_nx;
        end
    end

    assign in_ready_o  = (state == ACCUM);
    assign res_valid_o = (state == DONE);
    assign busy_o      = (state != IDLE);
    assign res_o       = res;
    assign ovf_o       = ovf;

endmodule

// File: tb/tb_mac_dot_seq.sv
// -----------------------------------------------------------------------------
// tb_mac_dot_seq
//
// Directed self-checking bench for mac_dot_seq. Inputs are driven and outputs
// sampled 1 time unit after the rising clock edge. Build with +define+MAC_RELU_EN
// to exercise the clamped-result variant.
// -----------------------------------------------------------------------------
module tb_mac_dot_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [15:0] len_i;
    logic [31:0] bias_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] act_i;
    logic [31:0] wgt_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [31:0] res_o;
    logic        ovf_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    mac_dot_seq #(.LEN_W(16)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .len_i       (len_i),
        .bias_i      (bias_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .act_i       (act_i),
        .wgt_i       (wgt_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_o       (res_o),
        .ovf_o       (ovf_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] relu_exp(input logic [31:0] v);
`ifdef MAC_RELU_EN
        return v[31] ? 32'd0 : v;
`else
        return v;
`endif
    endfunction

    function automatic int dot_ref(input logic [31:0] a, input logic [31:0] w);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            s += int'(a[8*k +: 8]) * int'($signed(w[8*k +: 8]));
        end
        return s;
    endfunction

    task automatic start_job(input logic [15:0] len, input logic [31:0] bias);
        start_i = 1'b1;
        len_i   = len;
        bias_i  = bias;
        step();
        start_i = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] w);
        in_valid_i = 1'b1;
        act_i      = a;
        wgt_i      = w;
        step();
        in_valid_i = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!res_valid_o && n < 20) begin
            step();
            n++;
        end
        check(tag, 32'(res_valid_o), 32'd1);
    endtask

    task automatic consume();
        res_ready_i = 1'b1;
        step();
        res_ready_i = 1'b0;
    endtask

    logic [31:0] fa [4];
    logic [31:0] fw [4];
    int          gaps [4];
    logic [31:0] exp_flow;
    logic [31:0] ovf_raw;

    initial begin
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        len_i       = '0;
        bias_i      = '0;
        in_valid_i  = 1'b0;
        act_i       = '0;
        wgt_i       = '0;
        res_ready_i = 1'b0;
        step();
        step();

        check("rst_in_ready",  32'(in_ready_o),  32'd0);
        check("rst_res_valid", 32'(res_valid_o), 32'd0);
        check("rst_ovf",       32'(ovf_o),       32'd0);
        check("rst_busy",      32'(busy_o),      32'd0);
        check("rst_res",       res_o,            32'd0);
        rst_ni = 1'b1;
        step();

        // basic: 4*1 + 3*1 + 2*1 + 1*1 = 10
        start_job(16'd1, 32'd0);
        check("basic_busy",     32'(busy_o),     32'd1);
        check("basic_in_ready", 32'(in_ready_o), 32'd1);
        send_beat(32'h0102_0304, 32'h0101_0101);
        check("basic_latency",  32'(res_valid_o), 32'd1);
        check("basic_res",      res_o,            32'd10);
        check("basic_ovf",      32'(ovf_o),       32'd0);
        consume();
        check("basic_idle",     32'(busy_o),      32'd0);

        // signed extremes: each beat 4 * 255 * -128 = -130560; 100 - 261120 = -261020
        start_job(16'd2, 32'd100);
        send_beat(32'hFFFF_FFFF, 32'h8080_8080);
        check("ext_mid_valid", 32'(res_valid_o), 32'd0);
        send_beat(32'hFFFF_FFFF, 32'h8080_8080);
        wait_valid("ext_valid");
        check("ext_res", res_o, relu_exp(32'hFFFC_0464));
        check("ext_ovf", 32'(ovf_o), 32'd0);
        consume();

        // zero length
        start_job(16'd0, 32'h1234_5678);
        check("zlen_valid",    32'(res_valid_o), 32'd1);
        check("zlen_in_ready", 32'(in_ready_o),  32'd0);
        check("zlen_res",      res_o,            32'h1234_5678);
        consume();

        // flow control: same four beats gap-free, then with input gaps
        fa[0] = 32'h1020_3040; fw[0] = 32'h01FF_02FE;
        fa[1] = 32'hFF80_0102; fw[1] = 32'h7F81_0A05;
        fa[2] = 32'h0000_00FF; fw[2] = 32'h0000_0080;
        fa[3] = 32'h7B2C_09D4; fw[3] = 32'hC03F_E711;
        gaps[0] = 1; gaps[1] = 3; gaps[2] = 2; gaps[3] = 0;
        exp_flow = 32'sd500;
        for (int i = 0; i < 4; i++) exp_flow = exp_flow + 32'(dot_ref(fa[i], fw[i]));

        start_job(16'd4, 32'd500);
        for (int i = 0; i < 4; i++) send_beat(fa[i], fw[i]);
        wait_valid("flow_nogap_valid");
        check("flow_nogap_res", res_o, relu_exp(exp_flow));
        consume();

        start_job(16'd4, 32'd500);
        for (int i = 0; i < 4; i++) begin
            send_beat(fa[i], fw[i]);
            for (int g = 0; g < gaps[i]; g++) step();
        end
        wait_valid("flow_gap_valid");
        for (int c = 0; c < 5; c++) begin
            check("flow_hold_res",      res_o,             relu_exp(exp_flow));
            check("flow_hold_valid",    32'(res_valid_o),  32'd1);
            check("flow_hold_busy",     32'(busy_o),       32'd1);
            check("flow_hold_in_ready", 32'(in_ready_o),   32'd0);
            step();
        end

        // release with a new start in the same cycle: no bubble
        res_ready_i = 1'b1;
        start_job(16'd1, 32'd0);
        res_ready_i = 1'b0;
        check("b2b_busy",     32'(busy_o),      32'd1);
        check("b2b_in_ready", 32'(in_ready_o),  32'd1);
        check("b2b_valid",    32'(res_valid_o), 32'd0);
        send_beat(32'h0102_0304, 32'h0101_0101);
        check("b2b_res",      res_o,            32'd10);
        consume();

        // overflow: 0x7FFFFF00 + 129540 wraps to 0x8001F904
        ovf_raw = 32'h8001_F904;
        start_job(16'd1, 32'h7FFF_FF00);
        send_beat(32'hFFFF_FFFF, 32'h7F7F_7F7F);
        wait_valid("ovf_valid");
        check("ovf_res",  res_o,       relu_exp(ovf_raw));
        check("ovf_flag", 32'(ovf_o),  32'd1);
        consume();
        step();
        check("ovf_sticky", 32'(ovf_o), 32'd1);
        start_job(16'd0, 32'd5);
        check("ovf_clear",  32'(ovf_o), 32'd0);
        check("ovf_next_res", res_o, 32'd5);
        consume();

        // reset in the middle of a job
        start_job(16'd8, 32'd7);
        for (int i = 0; i < 3; i++) send_beat(32'h0101_0101, 32'h0101_0101);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mrst_in_ready", 32'(in_ready_o),  32'd0);
        check("mrst_valid",    32'(res_valid_o), 32'd0);
        check("mrst_busy",     32'(busy_o),      32'd0);
        check("mrst_res",      res_o,            32'd0);
        check("mrst_ovf",      32'(ovf_o),       32'd0);
        step();
        rst_ni = 1'b1;
        step();
        check("mrst_idle_valid", 32'(res_valid_o), 32'd0);
        start_job(16'd1, 32'd0);
        send_beat(32'h0102_0304, 32'h0101_0101);
        wait_valid("mrst_after_valid");
        check("mrst_after_res", res_o, 32'd10);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
